// File: rtl/yags_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : yags_pkg
//  Description : Shared types, constants and saturating-counter helpers for
//                the YAGS branch predictor (choice PHT and exception caches).
//                Contents:
//                  ctr_t          2-bit saturating counter
//                  WEAK_T/WEAK_NT counter values written on allocation
//                  CTR_RESET      reset value of every choice counter
//                  cache_entry_t  {valid, tag, ctr} exception-cache entry
//                  sat_inc/sat_dec saturating counter steps
//  Revision    : 1.0 - initial release
// ============================================================================
package yags_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t WEAK_T    = 2'b10;
    localparam ctr_t WEAK_NT   = 2'b01;
    localparam ctr_t CTR_RESET = 2'b01;

    // Widest cache tag the entry type can hold. Narrower tags are stored
    // zero-extended, so the constant upper bits disappear in synthesis.
    localparam int MAX_TAG_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        ctr_t                 ctr;
    } cache_entry_t;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/yags_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : yags_predictor_if
//  Description : Pipeline-side bundle of the YAGS predictor.
//                ID group : PC_ID/branch_ID in, prediction and bookkeeping
//                           fields out (indices, hits, per-structure preds).
//                EX group : resolved branch (update_EX/taken_EX/PC_EX) plus
//                           the ID fields carried back through ID/EX.
//                YAGS_conflict : misprediction flag.
//                master = pipeline side, slave = predictor side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface yags_predictor_if #(
    parameter int PC_size = 10,
    parameter int size    = 32
);
    // ID-stage lookup
    logic [size-1:0]    PC_ID;
    logic               branch_ID;
    logic               YAGS_prediction_ID;
    logic               PHT_prediction_ID;
    logic [PC_size-1:0] Taken_Arr_Index_ID;
    logic [PC_size-1:0] Not_Taken_Arr_Index_ID;
    logic               Taken_Arr_hit_ID;
    logic               Not_Taken_Arr_hit_ID;
    logic               Taken_Arr_prediction_ID;
    logic               Not_Taken_Arr_prediction_ID;
    logic               T_NT_Arr_hit_ID;

    // EX-stage training
    logic               update_EX;
    logic               taken_EX;
    logic [size-1:0]    PC_EX;
    logic               YAGS_prediction_EX;
    logic               PHT_prediction_EX;
    logic [PC_size-1:0] Taken_Arr_Index_EX;
    logic [PC_size-1:0] Not_Taken_Arr_Index_EX;
    logic               T_NT_Arr_hit_EX;
    logic               Taken_Arr_hit_EX;
    logic               Not_Taken_Arr_hit_EX;
    logic               Taken_Arr_prediction_EX;
    logic               NOT_Taken_Arr_prediction_EX;
    logic               YAGS_conflict;

    modport master (
        output PC_ID, branch_ID,
        input  YAGS_prediction_ID, PHT_prediction_ID,
        input  Taken_Arr_Index_ID, Not_Taken_Arr_Index_ID,
        input  Taken_Arr_hit_ID, Not_Taken_Arr_hit_ID,
        input  Taken_Arr_prediction_ID, Not_Taken_Arr_prediction_ID,
        input  T_NT_Arr_hit_ID,
        output update_EX, taken_EX, PC_EX,
        output YAGS_prediction_EX, PHT_prediction_EX,
        output Taken_Arr_Index_EX, Not_Taken_Arr_Index_EX,
        output T_NT_Arr_hit_EX, Taken_Arr_hit_EX, Not_Taken_Arr_hit_EX,
        output Taken_Arr_prediction_EX, NOT_Taken_Arr_prediction_EX,
        input  YAGS_conflict
    );

    modport slave (
        input  PC_ID, branch_ID,
        output YAGS_prediction_ID, PHT_prediction_ID,
        output Taken_Arr_Index_ID, Not_Taken_Arr_Index_ID,
        output Taken_Arr_hit_ID, Not_Taken_Arr_hit_ID,
        output Taken_Arr_prediction_ID, Not_Taken_Arr_prediction_ID,
        output T_NT_Arr_hit_ID,
        input  update_EX, taken_EX, PC_EX,
        input  YAGS_prediction_EX, PHT_prediction_EX,
        input  Taken_Arr_Index_EX, Not_Taken_Arr_Index_EX,
        input  T_NT_Arr_hit_EX, Taken_Arr_hit_EX, Not_Taken_Arr_hit_EX,
        input  Taken_Arr_prediction_EX, NOT_Taken_Arr_prediction_EX,
        output YAGS_conflict
    );

endinterface
`default_nettype wire

// File: rtl/yags_cache.sv
`default_nettype none
// ============================================================================
//  Module      : yags_cache
//  Description : One YAGS exception cache (used for both the Taken and the
//                Not-Taken cache). 2^IDX_W entries of {valid, tag, ctr}.
//                Ports:
//                  clk, reset      clock, async active-low reset
//                  rd_index_i/rd_tag_i -> rd_hit_o, rd_pred_o (async read)
//                  wr_update_i     step the indexed counter toward outcome
//                  wr_alloc_i      overwrite entry with tag + weak counter
//                  wr_index_i/wr_tag_i/wr_taken_i  write address and data
//                TAG_W must not exceed yags_pkg::MAX_TAG_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module yags_cache
    import yags_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_index_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_hit_o,
    output logic             rd_pred_o,
    input  logic             wr_update_i,
    input  logic             wr_alloc_i,
    input  logic [IDX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_taken_i
);

    localparam int ENTRIES = 1 << IDX_W;

    // Packed array so the whole table clears with a single reset assignment.
    cache_entry_t [ENTRIES-1:0] entry_q;

    cache_entry_t         rd_entry;
    cache_entry_t         wr_old;
    cache_entry_t         wr_entry_d;
    logic [MAX_TAG_W-1:0] rd_tag_ext;
    logic [MAX_TAG_W-1:0] wr_tag_ext;

    assign rd_tag_ext = MAX_TAG_W'(rd_tag_i);
    assign wr_tag_ext = MAX_TAG_W'(wr_tag_i);

    // Read port: purely combinational, so a same-cycle write is not seen.
    assign rd_entry  = entry_q[rd_index_i];
    assign rd_hit_o  = rd_entry.valid && (rd_entry.tag == rd_tag_ext);
    assign rd_pred_o = rd_entry.ctr[1];

    always_comb begin
        wr_old     = entry_q[wr_index_i];
        wr_entry_d = wr_old;
        if (wr_alloc_i) begin
            wr_entry_d.valid = 1'b1;
            wr_entry_d.tag   = wr_tag_ext;
            wr_entry_d.ctr   = wr_taken_i ? WEAK_T : WEAK_NT;
        end else if (wr_update_i) begin
            wr_entry_d.ctr = wr_taken_i ? sat_inc(wr_old.ctr) : sat_dec(wr_old.ctr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q <= '0;
        end else if (wr_alloc_i || wr_update_i) begin
            entry_q[wr_index_i] <= wr_entry_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/yags_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : yags_predictor
//  Description : YAGS branch direction predictor. Holds the choice PHT, the
//                global history register and the update control; the two
//                exception caches are yags_cache instances.
//                Ports:
//                  clk    clock
//                  reset  asynchronous, active-low reset
//                  bus    yags_predictor_if.slave (ID lookup, EX training,
//                         YAGS_conflict)
//  Revision    : 1.0 - initial release
// ============================================================================
module yags_predictor
    import yags_pkg::*;
#(
    parameter int PC_size = 10,
    parameter int TAG_W   = 8,
    parameter int size    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    yags_predictor_if.slave        bus
);

    localparam int ENTRIES = 1 << PC_size;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctr_t [ENTRIES-1:0] choice_q;
    logic [PC_size-1:0] ghr_q;
    logic [PC_size-1:0] ghr_d;

    // ------------------------------------------------------------------
    // ID lookup
    // ------------------------------------------------------------------
    logic [PC_size-1:0] id_pc_idx;
    logic [PC_size-1:0] id_cache_idx;
    logic [TAG_W-1:0]   id_tag;
    logic               id_choice;
    logic               t_hit, t_pred;
    logic               nt_hit, nt_pred;
    logic               id_cons_hit;
    logic               id_pred;

    assign id_pc_idx    = bus.PC_ID[PC_size+1:2];
    assign id_cache_idx = id_pc_idx ^ ghr_q;
    assign id_tag       = bus.PC_ID[PC_size+TAG_W+1:PC_size+2];
    assign id_choice    = choice_q[id_pc_idx][1];

    // A choice of taken makes the NT cache the exception source, and vice versa.
    assign id_cons_hit = id_choice ? nt_hit : t_hit;
    assign id_pred     = id_cons_hit ? (id_choice ? nt_pred : t_pred) : id_choice;

    assign bus.YAGS_prediction_ID          = bus.branch_ID & id_pred;
    assign bus.PHT_prediction_ID           = id_choice;
    assign bus.Taken_Arr_Index_ID          = id_cache_idx;
    assign bus.Not_Taken_Arr_Index_ID      = id_cache_idx;
    assign bus.Taken_Arr_hit_ID            = t_hit;
    assign bus.Not_Taken_Arr_hit_ID        = nt_hit;
    assign bus.Taken_Arr_prediction_ID     = t_pred;
    assign bus.Not_Taken_Arr_prediction_ID = nt_pred;
    assign bus.T_NT_Arr_hit_ID             = id_cons_hit;

    // ------------------------------------------------------------------
    // EX update control
    // ------------------------------------------------------------------
    logic [PC_size-1:0] ex_pc_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_choice;
    logic               ex_choice_wrong;
    logic               ex_cons_pred;
    logic               choice_hold;
    ctr_t               choice_old;
    ctr_t               choice_d;
    logic               cache_update;
    logic               cache_alloc;
    logic               t_update, t_alloc;
    logic               nt_update, nt_alloc;

    assign ex_pc_idx       = bus.PC_EX[PC_size+1:2];
    assign ex_tag          = bus.PC_EX[PC_size+TAG_W+1:PC_size+2];
    assign ex_choice       = bus.PHT_prediction_EX;
    assign ex_choice_wrong = ex_choice != bus.taken_EX;
    assign ex_cons_pred    = ex_choice ? bus.NOT_Taken_Arr_prediction_EX
                                       : bus.Taken_Arr_prediction_EX;

    // When the exception cache already covered the choice PHT's mistake,
    // leave the choice counter alone so it keeps tracking the common bias.
    assign choice_hold = ex_choice_wrong && bus.T_NT_Arr_hit_EX
                         && (ex_cons_pred == bus.taken_EX);

    assign choice_old = choice_q[ex_pc_idx];
    assign choice_d   = choice_hold  ? choice_old :
                        bus.taken_EX ? sat_inc(choice_old) : sat_dec(choice_old);

    assign cache_update = bus.update_EX && bus.T_NT_Arr_hit_EX;
    assign cache_alloc  = bus.update_EX && !bus.T_NT_Arr_hit_EX && ex_choice_wrong;

    // Only the consulted cache is ever written.
    assign t_update  = cache_update && !ex_choice;
    assign t_alloc   = cache_alloc  && !ex_choice;
    assign nt_update = cache_update &&  ex_choice;
    assign nt_alloc  = cache_alloc  &&  ex_choice;

    assign ghr_d = {ghr_q[PC_size-2:0], bus.taken_EX};

    assign bus.YAGS_conflict = bus.update_EX && (bus.YAGS_prediction_EX != bus.taken_EX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            choice_q <= {ENTRIES{CTR_RESET}};
            ghr_q    <= '0;
        end else if (bus.update_EX) begin
            choice_q[ex_pc_idx] <= choice_d;
            ghr_q               <= ghr_d;
        end
    end

    // ------------------------------------------------------------------
    // Exception caches
    // ------------------------------------------------------------------
    yags_cache #(
        .IDX_W (PC_size),
        .TAG_W (TAG_W)
    ) u_t_cache (
        .clk         (clk),
        .reset       (reset),
        .rd_index_i  (id_cache_idx),
        .rd_tag_i    (id_tag),
        .rd_hit_o    (t_hit),
        .rd_pred_o   (t_pred),
        .wr_update_i (t_update),
        .wr_alloc_i  (t_alloc),
        .wr_index_i  (bus.Taken_Arr_Index_EX),
        .wr_tag_i    (ex_tag),
        .wr_taken_i  (bus.taken_EX)
    );

    yags_cache #(
        .IDX_W (PC_size),
        .TAG_W (TAG_W)
    ) u_nt_cache (
        .clk         (clk),
        .reset       (reset),
        .rd_index_i  (id_cache_idx),
        .rd_tag_i    (id_tag),
        .rd_hit_o    (nt_hit),
        .rd_pred_o   (nt_pred),
        .wr_update_i (nt_update),
        .wr_alloc_i  (nt_alloc),
        .wr_index_i  (bus.Not_Taken_Arr_Index_EX),
        .wr_tag_i    (ex_tag),
        .wr_taken_i  (bus.taken_EX)
    );

    // PC bits outside index/tag and the per-cache EX hit flags carry no
    // information the update needs (T_NT_Arr_hit_EX already selects).
    logic unused_ok;
    assign unused_ok = ^{bus.PC_ID[1:0], bus.PC_ID[size-1:PC_size+TAG_W+2],
                         bus.PC_EX[1:0], bus.PC_EX[size-1:PC_size+TAG_W+2],
                         bus.Taken_Arr_hit_EX, bus.Not_Taken_Arr_hit_EX};

endmodule
`default_nettype wire

// File: doc/yags_predictor.md
# yags_predictor

YAGS branch direction predictor serving the ID stage and trained from EX. Each cycle it reads the decoding instruction's PC and produces a direction prediction plus the bookkeeping fields (cache indices, hit flags, per-structure predictions) that the ID/EX pipeline register carries to EX. When a branch resolves in EX, the same fields come back and the block updates its choice PHT, its Taken/Not-Taken exception caches and its global history. It also raises `YAGS_conflict` on a misprediction.

## Interface
- `PC_size`, default 10: index width; choice PHT and each cache hold 2^PC_size entries; global history length equals `PC_size`.
- `TAG_W`, default 8: cache tag width.
- `size`, default 32: PC width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `PC_ID`  in  `size`  PC of the instruction in ID.
- `branch_ID`  in  1  instruction in ID is a conditional branch.
- `YAGS_prediction_ID`  out  1  final predicted direction (0 when `branch_ID`=0).
- `PHT_prediction_ID`  out  1  choice PHT counter MSB.
- `Taken_Arr_Index_ID`, `Not_Taken_Arr_Index_ID`  out  `PC_size`  cache index, both equal to `PC[PC_size+1:2] ^ GHR`.
- `Taken_Arr_hit_ID`, `Not_Taken_Arr_hit_ID`  out  1  raw valid+tag match in each cache.
- `Taken_Arr_prediction_ID`, `Not_Taken_Arr_prediction_ID`  out  1  counter MSB of the indexed cache entry.
- `T_NT_Arr_hit_ID`  out  1  hit in the consulted cache (NT cache if choice=1, T cache if choice=0).
- `update_EX`  in  1  resolved conditional branch in EX this cycle.
- `taken_EX`  in  1  actual outcome.
- `PC_EX`  in  `size`  PC of the resolving branch.
- `YAGS_prediction_EX`, `PHT_prediction_EX`, `Taken_Arr_Index_EX`, `Not_Taken_Arr_Index_EX`, `T_NT_Arr_hit_EX`, `Taken_Arr_hit_EX`, `Not_Taken_Arr_hit_EX`, `Taken_Arr_prediction_EX`, `NOT_Taken_Arr_prediction_EX`  in  as ID  the lookup fields, returned through the pipeline.
- `YAGS_conflict`  out  1  `update_EX & (YAGS_prediction_EX != taken_EX)`, combinational.

## Operation
- **State.**
  - Choice PHT: 2-bit saturating counters indexed by `PC[PC_size+1:2]`.
  - T cache and NT cache: entries of {valid, tag, 2-bit ctr}, with tag = `PC[PC_size+TAG_W+1:PC_size+2]`.
  - GHR: `PC_size` bits.
- **Lookup (combinational).**
  - The choice counter MSB selects which cache is consulted: choice=1 consults the NT cache, choice=0 consults the T cache.
  - On a consulted-cache hit, the prediction is that entry's ctr MSB. Otherwise it is the choice MSB.
- **Update.** On `update_EX`, all changes take effect at the next posedge.
  - **Choice counter:** moves toward `taken_EX`, except it is held when choice != outcome, `T_NT_Arr_hit_EX`=1, and the consulted cache's prediction equalled the outcome.
  - **Consulted cache, hit:** the counter moves toward the outcome.
  - **Consulted cache, miss and choice wrong:** allocate (overwrite) the entry: valid=1, tag from `PC_EX`, ctr=2'b10 if taken, else 2'b01.
  - **Consulted cache, miss and choice right:** no change.
  - **Non-consulted cache:** never written.
  - **GHR:** `GHR <= {GHR[PC_size-2:0], taken_EX}`.
- **Counter arithmetic.** 2-bit saturating: 11 does not increment, 00 does not decrement.

## Timing
- Lookup has zero latency: outputs are valid in the same cycle as `PC_ID`.
- An update is visible to lookups from the cycle after `update_EX`.
- If a lookup and an update hit the same entry in the same cycle, the lookup returns the pre-update value.
- GHR used for lookup is the non-speculative GHR. An update in the same cycle does not bypass into the current index.
- Reset values:
  - all choice counters 2'b01;
  - all cache valid bits 0 (tags and ctrs 0);
  - GHR 0.
- All lookup outputs follow from the reset state: `YAGS_prediction_ID`=0, all hits 0, `YAGS_conflict`=0 while `update_EX`=0.
- Reset asserted mid-operation clears state immediately (asynchronous). Updates in flight are lost.
- `update_EX` with `branch_ID`=1 in the same cycle is legal. Both happen independently.

## Structure
- Package `yags_pkg`:
  - `ctr_t` (2-bit);
  - constants `WEAK_T`=2'b10, `WEAK_NT`=2'b01, `CTR_RESET`=2'b01;
  - `cache_entry_t` struct {valid, tag, ctr};
  - functions `sat_inc` and `sat_dec`.
- Sub-module `yags_cache`, instantiated twice (T and NT). It provides:
  - async read port: index, tag in → hit, ctr MSB;
  - one write port: index, tag, ctr_update/allocate, outcome.
- The top level holds the choice PHT, the GHR and the control logic.

## Test plan
1. **Reset:** release reset, `PC_ID`=0x40, `branch_ID`=1 → `PHT_prediction_ID`=0, all hits 0, `YAGS_prediction_ID`=0, both indices 0x010.
2. **First taken branch:** update PC 0x40 taken, GHR=0, no hits.
   - `YAGS_conflict`=1 that cycle.
   - Next cycle: choice=2'b10, T cache[0x010] allocated with ctr 2'b10, GHR=0x001.
   - Lookup 0x40 → choice 1, consults NT cache (miss), predicts 1.
3. **Exception allocation:** choice[0x020]=2'b11 (PC 0x80), GHR=0; resolve not-taken.
   - Choice becomes 2'b10; NT cache[0x020] allocated with ctr 01.
   - After forcing GHR back to 0 via reset-and-retrain, lookup 0x80 → `Not_Taken_Arr_hit_ID`=1, predicts 0.
4. **Choice protection:** in the state of scenario 3, resolve 0x80 not-taken with NT hit and NT prediction 0 → choice stays 2'b10, NT ctr 01→00, `YAGS_conflict`=0.
5. **History and saturation:** updates T, N, T → GHR[2:0]=3'b101. Four taken updates on one PC → choice saturates at 2'b11 and stays there.
6. **Same-cycle and reset:** lookup and update of the same entry in one cycle → old prediction returned, new one the next cycle. Assert reset mid-run → all hits drop to 0 immediately.
